// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 state encodings, cycle defaults and command bytes.
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
  localparam int INHIBIT_CYCLES_DEF = 780;
  localparam int REQ_CYCLES_DEF = 8;
  localparam int TIMEOUT_CYCLES_DEF = 97500;
  localparam int CNT_W = 17;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop pad synchronizer with optional 4-sample stability filter and fall detect.
module ps2_line_sync #(
  parameter bit FILTER = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pad,
  output logic o_level,
  output logic o_fall
);
  logic r_s1, r_s2;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_pad;
      r_s2 <= r_s1;
    end
  end
  generate
    if (FILTER) begin : g_filt
      logic [2:0] r_hist;
      logic r_filt;
      logic w_all0, w_all1;
      assign w_all0 = ~|{r_hist, r_s2};
      assign w_all1 = &{r_hist, r_s2};
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_hist <= 3'b111;
          r_filt <= 1'b1;
        end else begin
          r_hist <= {r_hist[1:0], r_s2};
          r_filt <= w_all1 ? 1'b1 : w_all0 ? 1'b0 : r_filt;
        end
      end
      // Fall fires on the cycle the fourth low sample arrives, one cycle before r_filt drops.
      assign o_level = r_filt;
      assign o_fall = r_filt & w_all0;
    end else begin : g_raw
      logic r_prev;
      always_ff @(posedge clk) begin
        if (!reset) r_prev <= 1'b1;
        else r_prev <= r_s2;
      end
      assign o_level = r_s2;
      assign o_fall = r_prev & ~r_s2;
    end
  endgenerate
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with open-collector drive enables.
// Define PS2TX_GLITCH_FILTER_EN to filter the device clock through a 4-sample stability filter.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int REQ_CYCLES = REQ_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       clkps2_in,
  input  logic       dataps2_in,
  output logic       clkps2_drive_low,
  output logic       dataps2_drive_low
);
`ifdef PS2TX_GLITCH_FILTER_EN
  localparam bit CLK_FILTER = 1'b1;
`else
  localparam bit CLK_FILTER = 1'b0;
`endif
  localparam logic [CNT_W-1:0] L_INH = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_REQ = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TO = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t r_state, w_state;
  logic [7:0] r_data, w_data;
  logic r_par, w_par;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [3:0] r_idx, w_idx;
  logic r_busy, w_busy, r_done, w_done, r_err, w_err, r_cdl, w_cdl, r_ddl, w_ddl;
  logic w_clk, w_fall, w_dat, w_dat_fall_unused;
  ps2_line_sync #(.FILTER(CLK_FILTER)) u_clk_sync (
    .clk(clk), .reset(reset), .i_pad(clkps2_in), .o_level(w_clk), .o_fall(w_fall)
  );
  ps2_line_sync #(.FILTER(1'b0)) u_dat_sync (
    .clk(clk), .reset(reset), .i_pad(dataps2_in), .o_level(w_dat), .o_fall(w_dat_fall_unused)
  );
  always_comb begin
    w_state = r_state;
    w_data = r_data;
    w_par = r_par;
    w_cnt = (r_state == IDLE) ? '0 : r_cnt + CNT_W'(1);
    w_idx = r_idx;
    w_busy = r_busy;
    w_done = 1'b0;
    w_err = 1'b0;
    w_cdl = r_cdl;
    w_ddl = r_ddl;
    case (r_state)
      IDLE: if (tx_start) begin
        w_state = INHIBIT;
        w_data = tx_data;
        w_par = odd_parity(tx_data);
        w_busy = 1'b1;
        w_cdl = 1'b1;
      end
      INHIBIT: if (r_cnt == L_INH) begin
        w_state = REQ;
        w_cnt = '0;
        w_ddl = 1'b1;
      end
      REQ: if (r_cnt == L_REQ) begin
        w_state = SEND;
        w_cnt = '0;
        w_cdl = 1'b0;
        w_idx = '0;
      end
      SEND: if (w_fall) begin
        w_cnt = CNT_W'(1);
        w_idx = r_idx + 4'd1;
        w_ddl = (r_idx == 4'd8) ? ~r_par : (r_idx == 4'd9) ? 1'b0 : ~r_data[r_idx[2:0]];
        w_state = (r_idx == 4'd9) ? ACK : SEND;
      end
      ACK: if (w_fall) begin
        w_cnt = CNT_W'(1);
        w_state = w_dat ? IDLE : WAIT_IDLE;
        w_err = w_dat;
        w_busy = ~w_dat;
      end
      WAIT_IDLE: if (w_clk && w_dat) begin
        w_state = IDLE;
        w_done = 1'b1;
        w_busy = 1'b0;
      end
      default: w_state = IDLE;
    endcase
    // Watchdog: the counter restarts on each device clock fall, so it only expires on a stalled bus.
    if ((r_state inside {SEND, ACK, WAIT_IDLE}) && !w_fall && !w_done && r_cnt == L_TO) begin
      w_state = IDLE;
      w_err = 1'b1;
      w_busy = 1'b0;
      w_cdl = 1'b0;
      w_ddl = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_data <= '0;
      r_par <= 1'b0;
      r_cnt <= '0;
      r_idx <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_cdl <= 1'b0;
      r_ddl <= 1'b0;
    end else begin
      r_state <= w_state;
      r_data <= w_data;
      r_par <= w_par;
      r_cnt <= w_cnt;
      r_idx <= w_idx;
      r_busy <= w_busy;
      r_done <= w_done;
      r_err <= w_err;
      r_cdl <= w_cdl;
      r_ddl <= w_ddl;
    end
  end
  assign busy = r_busy;
  assign tx_done = r_done;
  assign tx_error = r_err;
  assign clkps2_drive_low = r_cdl;
  assign dataps2_drive_low = r_ddl;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-side PS/2 model plus a per-cycle expected-output model of the host transmitter.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  // Watchdog is scaled down so the stalled-bus case stays short.
  localparam int TO = 3000;
  localparam int H = 20;
`ifdef PS2TX_GLITCH_FILTER_EN
  localparam int FW = 4;
`else
  localparam int FW = 1;
`endif
  logic clk = 0, reset = 0, tx_start = 0;
  logic [7:0] tx_data = 0;
  logic busy, tx_done, tx_error, cdl, ddl;
  logic dev_clk = 1, dev_dat = 1;
  logic clk_bus, dat_bus;
  assign clk_bus = dev_clk & ~cdl;
  assign dat_bus = dev_dat & ~ddl;
  always #5 clk = ~clk;
  ps2_host_tx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
    .clkps2_in(clk_bus), .dataps2_in(dat_bus),
    .clkps2_drive_low(cdl), .dataps2_drive_low(ddl)
  );
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: k counts cycles since accept; kind 0 = acked, 1 = no ack, 2 = stalled bus.
  int smp = 0, m_k = 0, m_kind = 0, m_next_kind = 0, m_acc = 0;
  int m_falls = 0, m_upd_at = -1, m_end_at = -1, m_lo = 0, m_hi = 0;
  logic [10:0] m_seq;
  logic m_exp_ddl = 0, m_lvl = 1;
  bit m_fall;
  logic [4:0] m_exp;
  always @(posedge clk) begin
    #1;
    smp++;
    if (clk_bus) begin m_hi++; m_lo = 0; end else begin m_lo++; m_hi = 0; end
    m_fall = m_lvl && (m_lo >= FW);
    if (m_lo >= FW) m_lvl = 0; else if (m_hi >= FW) m_lvl = 1;
    if (!reset) m_k = 0;
    else if (m_k == 0 && tx_start) begin
      m_k = 1;
      m_acc++;
      m_kind = m_next_kind;
      m_seq = {1'b1, ~^tx_data, tx_data, 1'b0};
      m_falls = 0;
      m_exp_ddl = 1;
      m_upd_at = -1;
      m_end_at = -1;
    end else if (m_k > 0) m_k++;
    if (m_k > 788) begin
      if (m_fall) begin
        m_falls++;
        if (m_falls <= 10) m_upd_at = smp + 2;
        if (m_falls == 11 && m_kind == 1) m_end_at = smp + 2;
        if (m_kind == 2) m_end_at = smp + TO + 1;
      end
      if (smp == m_upd_at) m_exp_ddl = ~m_seq[m_falls];
      if (m_kind == 0 && m_falls == 11 && m_end_at < 0 && clk_bus && dat_bus) m_end_at = smp + 2;
    end
    if (m_k == 0) m_exp = 5'b00000;
    else if (smp == m_end_at) m_exp = {1'b0, m_kind == 0, m_kind != 0, 2'b00};
    else if (m_k <= 780) m_exp = 5'b10010;
    else if (m_k <= 788) m_exp = 5'b10011;
    else m_exp = {4'b1000, m_exp_ddl};
    chk("outputs{busy,done,err,cdl,ddl}", {busy, tx_done, tx_error, cdl, ddl}, m_exp);
    if (m_k > 0 && smp == m_end_at) m_k = 0;
  end
  task automatic start_tx(input logic [7:0] b, input int kind);
    int a0, t;
    @(negedge clk);
    a0 = m_acc;
    tx_data = b;
    tx_start = 1;
    m_next_kind = kind;
    t = 0;
    while (m_acc == a0 && t < 400) begin @(negedge clk); t++; end
    chk("accept", m_acc != a0, 1);
    tx_data = ~b;
    repeat (3) @(negedge clk);
    tx_start = 0;
  endtask
  task automatic dev_frame(input int nclk, input bit ack, input bit glitch, output logic [10:0] bits);
    int t;
    bits = '1;
    t = 0;
    while (!(clk_bus && !dat_bus) && t < 2000) begin @(negedge clk); t++; end
    chk("request", t < 2000, 1);
    if (t >= 2000) return;
    for (int i = 0; i < nclk; i++) begin
      if (glitch && i == 5) begin
        repeat (5) @(negedge clk);
        dev_clk = 0;
        repeat (2) @(negedge clk);
        dev_clk = 1;
        repeat (H - 7) @(negedge clk);
      end else repeat (H) @(negedge clk);
      bits[i] = dat_bus;
      if (i == 10 && ack) begin dev_dat = 0; repeat (2) @(negedge clk); end
      dev_clk = 0;
      repeat (H) @(negedge clk);
      dev_clk = 1;
    end
    repeat (H) @(negedge clk);
    dev_dat = 1;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (m_k != 0 && t < TO + 1000) begin @(negedge clk); t++; end
    chk("idle_reached", m_k == 0, 1);
  endtask
  task automatic send(input logic [7:0] b, input int kind, input int nclk, input bit ack,
                      input bit glitch, output logic [10:0] bits);
    start_tx(b, kind);
    dev_frame(nclk, ack, glitch, bits);
    if (nclk == 11) chk("frame", bits, {1'b1, ~^b, b, 1'b0});
    if (kind != 0) wait_idle();
  endtask
  logic [10:0] bits;
  logic [7:0] rb;
  int rk;
  initial begin
    repeat (5) @(negedge clk);
    reset = 1;
    repeat (5) @(negedge clk);
    send(8'hED, 0, 11, 1, 0, bits);
    chk("frame_ED_literal", bits, 11'h7DA);
    send(8'h00, 0, 11, 1, 0, bits);
    chk("frame_00_literal", bits, 11'h600);
    send(8'h01, 0, 11, 1, 0, bits);
    chk("frame_01_literal", bits, 11'h402);
    wait_idle();
    send(8'hFF, 1, 11, 0, 0, bits);
    send(8'hF4, 2, 4, 0, 0, bits);
    chk("partial_F4", bits[3:0], 4'b1000);
    rb = 8'($urandom);
    start_tx(rb, 2);
    dev_frame(5, 0, 0, bits);
    repeat (7) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    chk("reset_idle", m_k, 0);
    send(8'($urandom), 0, 11, 1, 0, bits);
`ifdef PS2TX_GLITCH_FILTER_EN
    send(8'hA5, 0, 11, 1, 1, bits);
`endif
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      rk = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send(rb, rk, 11, rk == 0, 0, bits);
    end
    wait_idle();
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
